// File: rtl/memory_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// memory_arbiter_rr_if
//   Bundles the per-core cache request/response signals and the single RAM port
//   handled by memory_arbiter_rr.
//
//   slave  : the arbiter's view. It takes cache requests and RAM status/data,
//            and drives the wait bits, the read-data broadcast and the RAM strobes.
//   master : the view of the environment (caches + RAM model, or a testbench).
//
//   Per-core vectors are packed with core c at [c*W +: W].
// -----------------------------------------------------------------------------
interface memory_arbiter_rr_if #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    // cache side
    logic [CPUS-1:0]        iREN;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*ADDR_W-1:0] iaddr;
    logic [CPUS*ADDR_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        iwait;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic [CPUS*WORD_W-1:0] dload;

    // RAM side
    logic [1:0]             ramstate;
    logic [WORD_W-1:0]      ramload;
    logic [ADDR_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic                   ramREN;
    logic                   ramWEN;

    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
        output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
    );

    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
        input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
    );
endinterface

// File: rtl/memory_arbiter_rr.sv
// -----------------------------------------------------------------------------
// memory_arbiter_rr
//   Round-robin arbiter placing CPUS cores (one I-port and one D-port each) onto
//   a single RAM port. D requests outrank I requests; within each class the
//   winner is the first requester at or after that class's pointer. A grant is
//   held until RAM reports ACCESS (transfer done) or the granted request drops.
//
// Ports
//   CLK      in   rising-edge clock
//   nRST     in   asynchronous active-low reset
//   bus      slave modport of memory_arbiter_rr_if:
//              iREN/dREN/dWEN, iaddr/daddr/dstore   per-core requests (in)
//              iwait/dwait                          0 = transfer completes now (out)
//              iload/dload                          ramload broadcast (out)
//              ramstate/ramload                     RAM status and read data (in)
//              ramaddr/ramstore/ramREN/ramWEN       RAM request (out)
//
// The interface instance must be built with the same CPUS/ADDR_W/WORD_W values.
// -----------------------------------------------------------------------------
module memory_arbiter_rr #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    memory_arbiter_rr_if.slave    bus
);

    localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;

    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [PTR_W-1:0]    sel_core_q, sel_core_d;
    logic                sel_is_d_q, sel_is_d_d;
    logic [PTR_W-1:0]    d_ptr_q,    d_ptr_d;
    logic [PTR_W-1:0]    i_ptr_q,    i_ptr_d;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Returns {found, index} of the first set bit of req at or after ptr,
    // wrapping around to core 0. The second pass covers the wrapped part.
    function automatic logic [PTR_W:0] rr_pick(
        input logic [CPUS-1:0]  req,
        input logic [PTR_W-1:0] ptr
    );
        logic             found;
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (!found && req[c] && (PTR_W'(c) >= ptr)) begin
                found = 1'b1;
                idx   = PTR_W'(c);
            end
        end
        for (int c = 0; c < CPUS; c++) begin
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = PTR_W'(c);
            end
        end
        return {found, idx};
    endfunction

    // (core + 1) mod CPUS without a divider.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] core);
        if (core == PTR_W'(CPUS - 1)) begin
            return '0;
        end
        return core + PTR_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Live view of the granted core's request signals
    // -------------------------------------------------------------------------
    logic              g_iren;
    logic              g_dren;
    logic              g_dwen;
    logic [ADDR_W-1:0] g_iaddr;
    logic [ADDR_W-1:0] g_daddr;
    logic [WORD_W-1:0] g_dstore;

    always_comb begin
        g_iren   = 1'b0;
        g_dren   = 1'b0;
        g_dwen   = 1'b0;
        g_iaddr  = '0;
        g_daddr  = '0;
        g_dstore = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (PTR_W'(c) == sel_core_q) begin
                g_iren   = bus.iREN[c];
                g_dren   = bus.dREN[c];
                g_dwen   = bus.dWEN[c];
                g_iaddr  = bus.iaddr[c*ADDR_W +: ADDR_W];
                g_daddr  = bus.daddr[c*ADDR_W +: ADDR_W];
                g_dstore = bus.dstore[c*WORD_W +: WORD_W];
            end
        end
    end

    // The grant is only alive while the granted port still asks for it; when it
    // drops, the strobes fall in the same cycle and the FSM aborts.
    logic req_live;
    logic ack;

    assign req_live = sel_is_d_q ? (g_dren | g_dwen) : g_iren;
    assign ack      = (state_q == GRANT) && req_live && (bus.ramstate == RAM_ACCESS);

    // -------------------------------------------------------------------------
    // RAM port and wait bits
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] ramaddr_o;
    logic [WORD_W-1:0] ramstore_o;
    logic              ramren_o;
    logic              ramwen_o;
    logic [CPUS-1:0]   iwait_o;
    logic [CPUS-1:0]   dwait_o;

    always_comb begin
        ramaddr_o  = '0;
        ramstore_o = '0;
        ramren_o   = 1'b0;
        ramwen_o   = 1'b0;
        iwait_o    = '1;
        dwait_o    = '1;
        if (state_q == GRANT) begin
            if (sel_is_d_q) begin
                ramaddr_o  = g_daddr;
                ramstore_o = g_dstore;
                // A write wins over a read on the same core, so the two RAM
                // strobes are mutually exclusive.
                ramwen_o   = g_dwen;
                ramren_o   = g_dren & ~g_dwen;
            end else begin
                ramaddr_o  = g_iaddr;
                ramren_o   = g_iren;
            end
            // Only ACCESS completes a transfer; FREE, BUSY and ERROR all stall.
            if (ack) begin
                for (int c = 0; c < CPUS; c++) begin
                    if (PTR_W'(c) == sel_core_q) begin
                        if (sel_is_d_q) begin
                            dwait_o[c] = 1'b0;
                        end else begin
                            iwait_o[c] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign bus.ramaddr  = ramaddr_o;
    assign bus.ramstore = ramstore_o;
    assign bus.ramREN   = ramren_o;
    assign bus.ramWEN   = ramwen_o;
    assign bus.iwait    = iwait_o;
    assign bus.dwait    = dwait_o;
    assign bus.iload    = {CPUS{bus.ramload}};
    assign bus.dload    = {CPUS{bus.ramload}};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [CPUS-1:0] d_req;
    logic [PTR_W:0]  d_pick;
    logic [PTR_W:0]  i_pick;

    assign d_req  = bus.dREN | bus.dWEN;
    assign d_pick = rr_pick(d_req, d_ptr_q);
    assign i_pick = rr_pick(bus.iREN, i_ptr_q);

    always_comb begin
        state_d    = state_q;
        sel_core_d = sel_core_q;
        sel_is_d_d = sel_is_d_q;
        d_ptr_d    = d_ptr_q;
        i_ptr_d    = i_ptr_q;
        case (state_q)
            IDLE: begin
                // Arbitration happens only here; arrivals during GRANT wait.
                if (d_pick[PTR_W]) begin
                    sel_core_d = d_pick[PTR_W-1:0];
                    sel_is_d_d = 1'b1;
                    state_d    = GRANT;
                end else if (i_pick[PTR_W]) begin
                    sel_core_d = i_pick[PTR_W-1:0];
                    sel_is_d_d = 1'b0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!req_live) begin
                    // Abort: pointer stays, so the same core keeps its turn.
                    state_d = IDLE;
                end else if (ack) begin
                    state_d = IDLE;
                    if (sel_is_d_q) begin
                        d_ptr_d = ptr_after(sel_core_q);
                    end else begin
                        i_ptr_d = ptr_after(sel_core_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            sel_core_q <= '0;
            sel_is_d_q <= 1'b0;
            d_ptr_q    <= '0;
            i_ptr_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_core_q <= sel_core_d;
            sel_is_d_q <= sel_is_d_d;
            d_ptr_q    <= d_ptr_d;
            i_ptr_q    <= i_ptr_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter_rr
//   Directed scenarios followed by a randomized phase, all checked each cycle
//   against a transaction-level model: "granted (core, class)" or idle, plus a
//   round-robin pointer per class.
// -----------------------------------------------------------------------------
module tb_memory_arbiter_rr;

    localparam int CPUS = 3;
    localparam int AW   = 32;
    localparam int WW   = 32;

    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    memory_arbiter_rr_if #(.CPUS(CPUS), .ADDR_W(AW), .WORD_W(WW)) bus ();

    memory_arbiter_rr #(.CPUS(CPUS), .ADDR_W(AW), .WORD_W(WW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int total  = 0;
    int passed = 0;

    // model state (m_*) and its value after the coming edge (n_*)
    bit m_busy, n_busy;
    int m_core, n_core;
    bit m_is_d, n_is_d;
    int m_dptr, n_dptr;
    int m_iptr, n_iptr;

    bit ack_seen;
    int ack_core;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_core = 0; m_is_d = 0; m_dptr = 0; m_iptr = 0;
        n_busy = 0; n_core = 0; n_is_d = 0; n_dptr = 0; n_iptr = 0;
    endtask

    function automatic int pick(input logic [CPUS-1:0] req, input int ptr);
        for (int k = 0; k < CPUS; k++) begin
            if (req[(ptr + k) % CPUS]) return (ptr + k) % CPUS;
        end
        return -1;
    endfunction

    task automatic set_i(input int c, input bit r, input logic [AW-1:0] a);
        bus.iREN[c]           = r;
        bus.iaddr[c*AW +: AW] = a;
    endtask

    task automatic set_d(input int c, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [WW-1:0] s);
        bus.dREN[c]            = rd;
        bus.dWEN[c]            = wr;
        bus.daddr[c*AW +: AW]  = a;
        bus.dstore[c*WW +: WW] = s;
    endtask

    // Compare outputs at the falling edge and work out the model's next state.
    task automatic sample();
        logic            e_ren, e_wen;
        logic [CPUS-1:0] e_iw, e_dw;
        bit              req, ack;
        int              c, p;
        @(negedge CLK);
        e_ren = 0; e_wen = 0; e_iw = '1; e_dw = '1; req = 0; ack = 0; c = m_core;
        if (m_busy) begin
            if (m_is_d) begin
                req   = bus.dREN[c] | bus.dWEN[c];
                e_wen = bus.dWEN[c];
                e_ren = bus.dREN[c] & ~bus.dWEN[c];
            end else begin
                req   = bus.iREN[c];
                e_ren = bus.iREN[c];
            end
            ack = req && (bus.ramstate == ACC);
            if (ack) begin
                if (m_is_d) e_dw[c] = 1'b0;
                else        e_iw[c] = 1'b0;
            end
        end
        chk("ramREN", bus.ramREN, e_ren);
        chk("ramWEN", bus.ramWEN, e_wen);
        chk("iwait",  bus.iwait,  e_iw);
        chk("dwait",  bus.dwait,  e_dw);
        if (m_busy && req)
            chk("ramaddr", bus.ramaddr, m_is_d ? bus.daddr[c*AW +: AW] : bus.iaddr[c*AW +: AW]);
        if (e_wen)
            chk("ramstore", bus.ramstore, bus.dstore[c*WW +: WW]);
        if (ack)
            chk("load", m_is_d ? bus.dload[c*WW +: WW] : bus.iload[c*WW +: WW], bus.ramload);
        ack_seen = ack;
        ack_core = c;

        n_busy = m_busy; n_core = m_core; n_is_d = m_is_d; n_dptr = m_dptr; n_iptr = m_iptr;
        if (!m_busy) begin
            p = pick(bus.dREN | bus.dWEN, m_dptr);
            if (p >= 0) begin
                n_busy = 1; n_core = p; n_is_d = 1;
            end else begin
                p = pick(bus.iREN, m_iptr);
                if (p >= 0) begin
                    n_busy = 1; n_core = p; n_is_d = 0;
                end
            end
        end else if (!req) begin
            n_busy = 0;
        end else if (ack) begin
            n_busy = 0;
            if (m_is_d) n_dptr = (c + 1) % CPUS;
            else        n_iptr = (c + 1) % CPUS;
        end
    endtask

    task automatic advance();
        @(posedge CLK);
        m_busy = n_busy; m_core = n_core; m_is_d = n_is_d; m_dptr = n_dptr; m_iptr = n_iptr;
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        int last, n_acks;
        bit have_last;

        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramstate = FREE; bus.ramload = '0;
        model_reset();

        // power-on reset
        #3;
        chk("rst_ramREN",   bus.ramREN,   1'b0);
        chk("rst_ramWEN",   bus.ramWEN,   1'b0);
        chk("rst_ramaddr",  bus.ramaddr,  32'h0);
        chk("rst_ramstore", bus.ramstore, 32'h0);
        chk("rst_iwait",    bus.iwait,    3'b111);
        chk("rst_dwait",    bus.dwait,    3'b111);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // single I fetch, ack on the 2nd GRANT cycle
        set_i(0, 1, 32'h100); bus.ramstate = BUSY;
        step();
        sample();
        chk("t2_ramaddr", bus.ramaddr, 32'h100);
        chk("t2_ramREN",  bus.ramREN,  1'b1);
        advance();
        bus.ramstate = ACC; bus.ramload = 32'hDEADBEEF;
        sample();
        chk("t2_iwait", bus.iwait, 3'b110);
        chk("t2_iload", bus.iload[31:0], 32'hDEADBEEF);
        advance();
        set_i(0, 0, 32'h0); bus.ramstate = FREE;
        step();

        // D write beats a simultaneous I fetch
        set_i(0, 1, 32'h200); set_d(1, 0, 1, 32'h40, 32'h5); bus.ramstate = ACC;
        step();
        sample();
        chk("t3_ramWEN",   bus.ramWEN,   1'b1);
        chk("t3_ramaddr",  bus.ramaddr,  32'h40);
        chk("t3_ramstore", bus.ramstore, 32'h5);
        chk("t3_dwait",    bus.dwait,    3'b101);
        advance();
        set_d(1, 0, 0, 32'h0, 32'h0);
        step();
        sample();
        chk("t3_i_ramaddr", bus.ramaddr, 32'h200);
        chk("t3_i_iwait",   bus.iwait,   3'b110);
        advance();
        set_i(0, 0, 32'h0);
        step();

        // two cores hold dREN, every GRANT cycle acked: grants alternate
        set_d(0, 1, 0, 32'h10, 32'h0); set_d(1, 1, 0, 32'h20, 32'h0); bus.ramstate = ACC;
        have_last = 0; last = 0; n_acks = 0;
        for (int k = 0; k < 12; k++) begin
            sample();
            if (ack_seen) begin
                n_acks++;
                if (have_last) chk("t4_alternate", ack_core, 1 - last);
                else           chk("t4_first", ack_core, 0);
                last = ack_core; have_last = 1;
            end
            advance();
        end
        chk("t4_acks", n_acks, 6);
        set_d(0, 0, 0, 32'h0, 32'h0); set_d(1, 0, 0, 32'h0, 32'h0);
        step();

        // abort: core1 dREN drops before ACCESS
        set_d(1, 1, 0, 32'h80, 32'h0); bus.ramstate = BUSY;
        step();
        sample();
        chk("t5_ramREN_on", bus.ramREN, 1'b1);
        advance();
        set_d(1, 0, 0, 32'h80, 32'h0); bus.ramstate = ACC;
        sample();
        chk("t5_ramREN_off", bus.ramREN, 1'b0);
        chk("t5_dwait",      bus.dwait,  3'b111);
        advance();
        // d_ptr still 2: core2 beats core0
        set_d(0, 1, 0, 32'h300, 32'h0); set_d(2, 1, 0, 32'h302, 32'h0); bus.ramstate = BUSY;
        step();
        sample();
        chk("t5_ptr_kept", bus.ramaddr, 32'h302);
        advance();

        // ERROR for 5 cycles, then ACCESS
        bus.ramstate = ERR;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("t6_err_dwait", bus.dwait, 3'b111);
            advance();
        end
        bus.ramstate = ACC;
        sample();
        chk("t6_ack", bus.dwait, 3'b011);
        advance();
        set_d(0, 0, 0, 32'h0, 32'h0); set_d(2, 0, 0, 32'h0, 32'h0); bus.ramstate = FREE;
        step();

        // reset mid-GRANT with non-zero pointers
        set_d(1, 1, 0, 32'h90, 32'h0); bus.ramstate = ACC;
        step();
        step();
        set_d(1, 0, 1, 32'h94, 32'h7); bus.ramstate = BUSY;
        set_i(0, 1, 32'h400);
        step();
        step();
        step();
        step();
        set_i(0, 0, 32'h0);
        step();
        set_d(1, 0, 1, 32'h98, 32'h9);
        step();
        sample();
        chk("t1_pre_ramWEN", bus.ramWEN, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        chk("t1_ramWEN",  bus.ramWEN,  1'b0);
        chk("t1_ramREN",  bus.ramREN,  1'b0);
        chk("t1_iwait",   bus.iwait,   3'b111);
        chk("t1_dwait",   bus.dwait,   3'b111);
        chk("t1_ramaddr", bus.ramaddr, 32'h0);
        model_reset();
        set_d(1, 0, 0, 32'h0, 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        set_d(0, 1, 0, 32'h500, 32'h0); set_d(2, 1, 0, 32'h502, 32'h0);
        step();
        sample();
        chk("t1_dptr_zero", bus.ramaddr, 32'h500);
        advance();
        set_d(0, 0, 0, 32'h0, 32'h0); set_d(2, 0, 0, 32'h0, 32'h0);
        step();
        set_i(0, 1, 32'h600); set_i(1, 1, 32'h601);
        step();
        sample();
        chk("t1_iptr_zero", bus.ramaddr, 32'h600);
        advance();
        set_i(0, 0, 32'h0); set_i(1, 0, 32'h0);
        step();

        // randomized traffic with sticky requests
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < CPUS; c++) begin
                bit r;
                r = bus.iREN[c] ? ($urandom_range(99) < 85) : ($urandom_range(99) < 30);
                set_i(c, r, $urandom);
                bus.dREN[c] = bus.dREN[c] ? ($urandom_range(99) < 85) : ($urandom_range(99) < 25);
                bus.dWEN[c] = bus.dWEN[c] ? ($urandom_range(99) < 85) : ($urandom_range(99) < 15);
                bus.daddr[c*AW +: AW]  = $urandom;
                bus.dstore[c*WW +: WW] = $urandom;
            end
            case ($urandom_range(9))
                0, 1:    bus.ramstate = BUSY;
                2:       bus.ramstate = FREE;
                3:       bus.ramstate = ERR;
                default: bus.ramstate = ACC;
            endcase
            bus.ramload = $urandom;
            sample();
            chk("excl_strobes", bus.ramREN & bus.ramWEN, 1'b0);
            advance();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
